// File: rtl/vec_mul_pkg.sv
// -----------------------------------------------------------------------------
// vec_mul_pkg
// Shared definitions for the vector-multiplier tile sequencer:
//   - default ADDRESSSIZE / MATRIX_SIZE / perf counter width
//   - 3-bit FSM state encoding
//   - pipe_lat_f(): drain length after the last valid address (2*M+1)
// Optional feature macro used by the importing RTL: VEC_MUL_PERF_CNT_EN
// -----------------------------------------------------------------------------
package vec_mul_pkg;

    localparam int ADDRESSSIZE_DEF = 10;
    localparam int MATRIX_SIZE_DEF = 8;
    localparam int CNT_W_DEF       = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT_W = 3'd1;
    localparam logic [2:0] ST_POP    = 3'd2;
    localparam logic [2:0] ST_RELOAD = 3'd3;
    localparam logic [2:0] ST_STREAM = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    // A vector entering the systolic array needs 2*M+1 cycles to fully leave it.
    function automatic int pipe_lat_f(input int matrix_size);
        return 2 * matrix_size + 1;
    endfunction

endpackage

// File: rtl/vec_mul_perf_cnt.sv
// -----------------------------------------------------------------------------
// vec_mul_perf_cnt
// Two independent saturating event counters with a shared synchronous clear.
// Only instantiated when VEC_MUL_PERF_CNT_EN is defined.
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   clear         synchronous clear of both counters (has priority)
//   inc_a, inc_b  increment strobes
//   cnt_a, cnt_b  registered counts, stick at all-ones
// -----------------------------------------------------------------------------
module vec_mul_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc_a,
    input  logic             inc_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Counter A: clear on tile start, otherwise saturating increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_a <= {CNT_W{1'b0}};
        end else if (inc_a && (cnt_a != CNT_MAX)) begin
            cnt_a <= cnt_a + CNT_ONE;
        end else begin
            cnt_a <= cnt_a;
        end
    end

    // Counter B: clear on tile start, otherwise saturating increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_b <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_b <= {CNT_W{1'b0}};
        end else if (inc_b && (cnt_b != CNT_MAX)) begin
            cnt_b <= cnt_b + CNT_ONE;
        end else begin
            cnt_b <= cnt_b;
        end
    end

endmodule

// File: rtl/vec_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// vec_mul_seq_ctrl
// Tile sequencer for the vector-multiplier top. On start it waits for the
// weight FIFO, pops one row-set, pulses weight_reload, streams cfg_num_vec
// consecutive input-SRAM addresses with valid_address, drains the array
// pipeline for PIPE_LAT cycles and pulses done.
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   start, abort        tile request (IDLE only) / synchronous abort
//   cfg_base_addr       first SRAM address, cfg_num_vec vectors (0 -> err)
//   fifo_empty          weight FIFO empty flag; fifo_read_enable pop strobe
//   weight_reload       load popped weights into the PE array
//   valid_address       sram_address carries a valid vector address
//   sram_write_enable   1 only in IDLE (host access window)
//   busy, done, err     status; done/err are one-cycle pulses
//   perf_cycles/stalls  busy / FIFO-stall cycles of the last tile
// Optional feature: define VEC_MUL_PERF_CNT_EN to build the perf counters;
// otherwise the perf outputs are tied to zero.
// All outputs are registered: each is computed from the next state.
// -----------------------------------------------------------------------------
module vec_mul_seq_ctrl
    import vec_mul_pkg::*;
#(
    parameter int ADDRESSSIZE = ADDRESSSIZE_DEF,
    parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
    parameter int PIPE_LAT    = pipe_lat_f(MATRIX_SIZE),
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] cfg_base_addr,
    input  logic [ADDRESSSIZE-1:0] cfg_num_vec,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   weight_reload,
    output logic                   valid_address,
    output logic [ADDRESSSIZE-1:0] sram_address,
    output logic                   sram_write_enable,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [CNT_W-1:0]       perf_cycles,
    output logic [CNT_W-1:0]       perf_stalls
);

    localparam int DRAIN_W = $clog2(PIPE_LAT + 1);
    localparam logic [ADDRESSSIZE-1:0] ADDR_ZERO = {ADDRESSSIZE{1'b0}};
    localparam logic [ADDRESSSIZE-1:0] ADDR_ONE  = {{(ADDRESSSIZE-1){1'b0}}, 1'b1};
    localparam logic [ADDRESSSIZE-1:0] ADDR_ONES = {ADDRESSSIZE{1'b1}};
    localparam logic [DRAIN_W-1:0]     DRN_ONE   = {{(DRAIN_W-1){1'b0}}, 1'b1};
    localparam logic [DRAIN_W-1:0]     DRN_LAST  = DRAIN_W'(PIPE_LAT - 1);

    logic [2:0]             state_r;
    logic [2:0]             next_state_s;
    logic [ADDRESSSIZE-1:0] base_r;
    logic [ADDRESSSIZE-1:0] num_r;
    logic [ADDRESSSIZE-1:0] vec_cnt_r;
    logic [DRAIN_W-1:0]     drain_cnt_r;
    logic                   start_ok_s;
    logic                   last_vec_s;
    logic                   last_drain_s;

    logic                   fifo_read_enable_s;
    logic                   weight_reload_s;
    logic                   valid_address_s;
    logic [ADDRESSSIZE-1:0] sram_address_s;
    logic                   sram_write_enable_s;
    logic                   busy_s;
    logic                   done_s;
    logic                   err_s;

    // Abort has priority over start even though abort alone does nothing in IDLE.
    assign start_ok_s   = (state_r == ST_IDLE) && start && !abort && (cfg_num_vec != ADDR_ZERO);
    assign last_vec_s   = (vec_cnt_r == (num_r - ADDR_ONE));
    assign last_drain_s = (drain_cnt_r == DRN_LAST);

    // State register plus latched config and inline vector / drain counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            base_r      <= ADDR_ZERO;
            num_r       <= ADDR_ZERO;
            vec_cnt_r   <= ADDR_ZERO;
            drain_cnt_r <= {DRAIN_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (start_ok_s) begin
                base_r <= cfg_base_addr;
                num_r  <= cfg_num_vec;
            end else begin
                base_r <= base_r;
                num_r  <= num_r;
            end
            vec_cnt_r   <= ((state_r == ST_STREAM) && (next_state_s == ST_STREAM))
                           ? (vec_cnt_r + ADDR_ONE) : ADDR_ZERO;
            drain_cnt_r <= ((state_r == ST_DRAIN) && (next_state_s == ST_DRAIN))
                           ? (drain_cnt_r + DRN_ONE) : {DRAIN_W{1'b0}};
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        if (abort && (state_r != ST_IDLE)) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   next_state_s = start_ok_s ? ST_WAIT_W : ST_IDLE;
                ST_WAIT_W: next_state_s = fifo_empty ? ST_WAIT_W : ST_POP;
                ST_POP:    next_state_s = ST_RELOAD;
                ST_RELOAD: next_state_s = ST_STREAM;
                ST_STREAM: next_state_s = last_vec_s ? ST_DRAIN : ST_STREAM;
                ST_DRAIN:  next_state_s = last_drain_s ? ST_DONE : ST_DRAIN;
                ST_DONE:   next_state_s = ST_IDLE;
                default:   next_state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the state being entered, so the output flops line up with it
    always_comb begin
        fifo_read_enable_s  = 1'b0;
        weight_reload_s     = 1'b0;
        valid_address_s     = 1'b0;
        sram_address_s      = ADDR_ZERO;
        sram_write_enable_s = 1'b0;
        done_s              = 1'b0;
        busy_s              = (next_state_s != ST_IDLE);
        err_s               = (abort && (state_r != ST_IDLE)) ||
                              ((state_r == ST_IDLE) && start && !abort && (cfg_num_vec == ADDR_ZERO));
        case (next_state_s)
            ST_IDLE:   sram_write_enable_s = 1'b1;
            ST_WAIT_W: sram_write_enable_s = 1'b0;
            ST_POP:    fifo_read_enable_s  = 1'b1;
            ST_RELOAD: weight_reload_s     = 1'b1;
            ST_STREAM: begin
                valid_address_s = 1'b1;
                // Address wraps modulo 2^ADDRESSSIZE by construction of the adder width
                sram_address_s  = base_r + ((state_r == ST_STREAM) ? (vec_cnt_r + ADDR_ONE) : ADDR_ZERO);
            end
            ST_DRAIN:  sram_address_s = ADDR_ONES;
            ST_DONE:   done_s         = 1'b1;
            default:   sram_write_enable_s = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_read_enable  <= 1'b0;
            weight_reload     <= 1'b0;
            valid_address     <= 1'b0;
            sram_address      <= ADDR_ZERO;
            sram_write_enable <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
        end else begin
            fifo_read_enable  <= fifo_read_enable_s;
            weight_reload     <= weight_reload_s;
            valid_address     <= valid_address_s;
            sram_address      <= sram_address_s;
            sram_write_enable <= sram_write_enable_s;
            busy              <= busy_s;
            done              <= done_s;
            err               <= err_s;
        end
    end

`ifdef VEC_MUL_PERF_CNT_EN
    // Counters clear on the accepting edge (state is IDLE then, so no increment collides)
    vec_mul_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (start_ok_s),
        .inc_a (state_r != ST_IDLE),
        .inc_b ((state_r == ST_WAIT_W) && fifo_empty),
        .cnt_a (perf_cycles),
        .cnt_b (perf_stalls)
    );
`else
    assign perf_cycles = {CNT_W{1'b0}};
    assign perf_stalls = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vec_mul_seq_ctrl
// Self-checking bench for vec_mul_seq_ctrl. Expected outputs come from a
// timeline model: for a tile started at cycle 0 with S stall cycles, every
// output at cycle k is derived from the tile schedule with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_vec_mul_seq_ctrl;

    localparam int AW = 10;
    localparam int MS = 8;
    localparam int PL = 2 * MS + 1;
    localparam int CW = 16;

    typedef struct packed {
        logic          busy;
        logic          fre;
        logic          wr;
        logic          valid;
        logic [AW-1:0] addr;
        logic          done;
        logic          err;
        logic          we;
    } obs_t;

    typedef struct {
        string name;
        int    base;
        int    num;
        int    stalls;
        int    abort_at;
        int    exp_cycles;
        int    exp_stalls;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] cfg_base_addr;
    logic [AW-1:0] cfg_num_vec;
    logic          fifo_empty;
    logic          fifo_read_enable;
    logic          weight_reload;
    logic          valid_address;
    logic [AW-1:0] sram_address;
    logic          sram_write_enable;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] perf_cycles;
    logic [CW-1:0] perf_stalls;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_mul_seq_ctrl #(
        .ADDRESSSIZE (AW),
        .MATRIX_SIZE (MS),
        .CNT_W       (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_num_vec       (cfg_num_vec),
        .fifo_empty        (fifo_empty),
        .fifo_read_enable  (fifo_read_enable),
        .weight_reload     (weight_reload),
        .valid_address     (valid_address),
        .sram_address      (sram_address),
        .sram_write_enable (sram_write_enable),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .perf_cycles       (perf_cycles),
        .perf_stalls       (perf_stalls)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic obs_t cur_obs();
        obs_t o;
        o = '{busy, fifo_read_enable, weight_reload, valid_address, sram_address,
              done, err, sram_write_enable};
        return o;
    endfunction

    // Reference schedule: start sampled at cycle 0, S stall cycles, abort sampled at cycle ab (0 = none)
    function automatic obs_t exp_obs(input int k, input int base, input int num, input int s, input int ab);
        obs_t o;
        int   done_k;
        o      = '0;
        done_k = 4 + s + num + PL;
        if (ab > 0 && k > ab) begin
            o.we  = 1'b1;
            o.err = (k == ab + 1);
            return o;
        end
        if (k > done_k) begin
            o.we = 1'b1;
            return o;
        end
        o.busy = 1'b1;
        o.fre  = (k == 2 + s);
        o.wr   = (k == 3 + s);
        if (k >= 4 + s && k <= 3 + s + num) begin
            o.valid = 1'b1;
            o.addr  = AW'((base + k - 4 - s) % (1 << AW));
        end else if (k >= 4 + s + num && k < done_k) begin
            o.addr = {AW{1'b1}};
        end
        o.done = (k == done_k);
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tile(input string nm, input int base, input int num, input int s,
                            input int ab, input int ecyc, input int estl);
        int last;
        last = (ab > 0) ? ab + 1 : 4 + s + num + PL + 1;
        cfg_base_addr = AW'(base);
        cfg_num_vec   = AW'(num);
        start         = 1'b1;
        abort         = 1'b0;
        fifo_empty    = (s > 0);
        step();
        // Config changes after the accepting edge must have no effect
        cfg_base_addr = AW'($urandom);
        cfg_num_vec   = AW'($urandom);
        for (int k = 1; k <= last; k++) begin
            chk($sformatf("%s k=%0d", nm, k), 64'(cur_obs()), 64'(exp_obs(k, base, num, s, ab)));
            if (k < last) begin
                fifo_empty = (k <= s) ? 1'b1 : ((k == s + 1) ? 1'b0 : 1'($urandom_range(0, 1)));
                abort      = (k == ab);
                start      = 1'($urandom_range(0, 1));
                step();
            end
        end
        start      = 1'b0;
        abort      = 1'b0;
        fifo_empty = 1'b0;
`ifdef VEC_MUL_PERF_CNT_EN
        chk({nm, " perf_cycles"}, 64'(perf_cycles), 64'(ecyc));
        chk({nm, " perf_stalls"}, 64'(perf_stalls), 64'(estl));
`else
        chk({nm, " perf_cycles"}, 64'(perf_cycles), 64'(ecyc * 0));
        chk({nm, " perf_stalls"}, 64'(perf_stalls), 64'(estl * 0));
`endif
    endtask

    initial begin
        vec_t tbl[8];
        int   num;
        int   s;
        int   base;
        int   ab;
        int   dk;

        tbl[0] = '{"base0_n8",     0,    8, 0, 0,  29, 0};
        tbl[1] = '{"stall5",       0,    8, 5, 0,  34, 5};
        tbl[2] = '{"wrap1020",     1020, 8, 0, 0,  29, 0};
        tbl[3] = '{"abort_str3",   37,   8, 0, 6,  6,  0};
        tbl[4] = '{"after_abort",  5,    3, 1, 0,  25, 1};
        tbl[5] = '{"n1",           500,  1, 0, 0,  22, 0};
        tbl[6] = '{"abort_wait",   1023, 2, 2, 2,  2,  2};
        tbl[7] = '{"abort_done",   200,  4, 0, 25, 25, 0};

        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        fifo_empty    = 1'b0;
        cfg_base_addr = '0;
        cfg_num_vec   = '0;

        #12;
        chk("reset outputs", 64'(cur_obs()), 64'(0));
        chk("reset perf", 64'({perf_cycles, perf_stalls}), 64'(0));
        rst = 1'b0;
        step();
        chk("idle after reset", 64'(cur_obs()), 64'(17'h1));

        for (int i = 0; i < 8; i++) begin
            run_tile(tbl[i].name, tbl[i].base, tbl[i].num, tbl[i].stalls,
                     tbl[i].abort_at, tbl[i].exp_cycles, tbl[i].exp_stalls);
        end

        // Zero-length request: err pulse only, no tile
        cfg_num_vec = '0;
        start       = 1'b1;
        step();
        chk("n0 err", 64'(cur_obs()), 64'(17'h3));
        start = 1'b0;
        step();
        chk("n0 after", 64'(cur_obs()), 64'(17'h1));

        // Abort together with start in IDLE: abort wins, nothing happens
        cfg_num_vec = AW'(5);
        start       = 1'b1;
        abort       = 1'b1;
        step();
        chk("abort+start idle", 64'(cur_obs()), 64'(17'h1));
        start = 1'b0;
        abort = 1'b0;
        step();
        chk("abort+start idle next", 64'(cur_obs()), 64'(17'h1));

        // Randomised tiles against the schedule model
        for (int i = 0; i < 20; i++) begin
            num  = $urandom_range(1, 12);
            s    = $urandom_range(0, 3);
            base = $urandom_range(0, 1023);
            dk   = 4 + s + num + PL;
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dk) : 0;
            run_tile($sformatf("rnd%0d", i), base, num, s, ab,
                     (ab > 0) ? ab : dk, (ab > 0) ? ((s < ab) ? s : ab) : s);
        end

        // Asynchronous reset in the middle of DRAIN
        cfg_base_addr = AW'(100);
        cfg_num_vec   = AW'(4);
        start         = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        chk("pre-rst in drain", 64'(cur_obs()), 64'(exp_obs(13, 100, 4, 0, 0)));
        #2;
        rst = 1'b1;
        #1;
        chk("async rst outputs", 64'(cur_obs()), 64'(0));
        chk("async rst perf", 64'({perf_cycles, perf_stalls}), 64'(0));
        #2;
        rst = 1'b0;
        step();
        chk("idle after mid rst", 64'(cur_obs()), 64'(17'h1));
        repeat (3) step();
        chk("no late pop", 64'(cur_obs()), 64'(17'h1));

        run_tile("post_rst", 7, 5, 0, 0, 26, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
